// File: rtl/bfp_conv_mac_pkg.sv
// Shared types and constants for the BFP 3x3 convolution MAC datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bfp_pkg;

    localparam int EXP_SIZE    = 5;
    localparam int MANT_SIZE   = 10;
    localparam int DATA_WIDTH  = 1 + EXP_SIZE + MANT_SIZE;
    localparam int WEIGHT_W    = 8;
    localparam int WEIGHT_FRAC = 6;
    localparam int ACC_W       = MANT_SIZE + WEIGHT_W + 4;
    localparam int N_TAPS      = 9;
    localparam int ELEM_W      = MANT_SIZE + 1;
    localparam int PROD_W      = ELEM_W + WEIGHT_W;
    localparam int BIAS_W      = 16;

    typedef struct packed {
        logic                 sign;
        logic [MANT_SIZE-1:0] mag;
    } sm_elem_t;

    typedef struct packed {
        logic                 sign;
        logic [EXP_SIZE-1:0]  exp;
        logic [MANT_SIZE-1:0] frac;
    } fp16_t;

    localparam fp16_t FP16_ZERO    = 16'h0000;
    localparam fp16_t FP16_POS_SAT = 16'h7BFF;
    localparam fp16_t FP16_NEG_SAT = 16'hFBFF;

    // Sign-magnitude element to two's complement, one bit wider than the magnitude.
    function automatic logic signed [ELEM_W-1:0] sm_to_signed(sm_elem_t e);
        logic signed [ELEM_W-1:0] m;
        m = $signed({1'b0, e.mag});
        return e.sign ? -m : m;
    endfunction

endpackage

// File: rtl/bfp_conv_mac_if.sv
// Window/weight/result bus of the BFP convolution MAC.
// Latency: n/a (interface only).
// Backpressure: in_valid/in_ready on the window side, out_valid/out_ready on the result side.
// Ports: slave = MAC side, master = producer/consumer side.
interface bfp_conv_mac_if;
    import bfp_pkg::*;

    logic                       in_valid;
    logic                       in_ready;
    logic [N_TAPS*ELEM_W-1:0]   in_mant;
    logic [EXP_SIZE-1:0]        in_max_exp;
    logic                       w_load;
    logic [3:0]                 w_addr;
    logic [WEIGHT_W-1:0]        w_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_WIDTH-1:0]      out_data;

    modport slave (
        input  in_valid, in_mant, in_max_exp, w_load, w_addr, w_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_mant, in_max_exp, w_load, w_addr, w_data, out_ready,
        input  in_ready, out_valid, out_data
    );

endinterface

// File: rtl/bfp_fp_pack.sv
// Renormalizes a signed accumulator plus block exponent into one FP16 word.
// Latency: combinational; the parent registers the result.
// Backpressure: none (pure function of its inputs).
// Ports: acc_i (signed accumulator), max_exp_i (block exponent), fp_o (packed FP16).
module bfp_fp_pack
    import bfp_pkg::*;
(
    input  logic signed [ACC_W-1:0]    acc_i,
    input  logic        [EXP_SIZE-1:0] max_exp_i,
    output fp16_t                      fp_o
);

    localparam int P_W = $clog2(ACC_W);
    localparam int E_W = 8;
    localparam logic signed [E_W-1:0] E_SAT = E_W'((1 << EXP_SIZE) - 1);

    logic                  sign;
    logic [ACC_W-1:0]      mag;
    logic [P_W-1:0]        lead;
    logic signed [E_W-1:0] e;
    logic [ACC_W-1:0]      aligned;

    always_comb begin
        sign = acc_i[ACC_W-1];
        mag  = sign ? $unsigned(-acc_i) : $unsigned(acc_i);

        lead = '0;
        for (int i = 0; i < ACC_W; i++) begin
            if (mag[i]) lead = P_W'(i);
        end

        // Wide signed exponent so small blocks go negative instead of wrapping.
        e = $signed(E_W'(lead)) + $signed(E_W'(max_exp_i)) - $signed(E_W'(MANT_SIZE + WEIGHT_FRAC));

        // Leading one moves to the MSB; the MANT_SIZE bits beneath it are the fraction,
        // zero-filled when the magnitude is short and truncated when it is long.
        aligned = mag << (P_W'(ACC_W - 1) - lead);

        fp_o = FP16_ZERO;
        if (mag == '0 || e <= 0) begin
            fp_o = FP16_ZERO;
        end else if (e >= E_SAT) begin
            fp_o = sign ? FP16_NEG_SAT : FP16_POS_SAT;
        end else begin
            fp_o.sign = sign;
            fp_o.exp  = e[EXP_SIZE-1:0];
            fp_o.frac = MANT_SIZE'(aligned >> (ACC_W - 1 - MANT_SIZE));
        end
    end

endmodule

// File: rtl/bfp_conv_mac.sv
// 3x3 BFP window times stored Q1.6 kernel, summed and renormalized to one FP16 pixel.
// Latency: 3 cycles accept-to-out_valid, 1 window/cycle.
// Backpressure: whole pipe holds while out_valid && !out_ready; in_ready mirrors advance.
// Ports: clk, rst (sync, active-high), bus (bfp_conv_mac_if.slave).
// Optional: BFP_CONV_MAC_BIAS_EN adds a 16-bit bias register at weight address 9.
module bfp_conv_mac
    import bfp_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    bfp_conv_mac_if.slave   bus
);

    logic adv;

    logic signed [WEIGHT_W-1:0] w_q [N_TAPS];
`ifdef BFP_CONV_MAC_BIAS_EN
    logic signed [BIAS_W-1:0]   bias_q;
`endif

    logic                       s1_vld_q;
    logic signed [PROD_W-1:0]   prod_q [N_TAPS];
    logic signed [PROD_W-1:0]   prod_d [N_TAPS];
    logic [EXP_SIZE-1:0]        s1_exp_q;

    logic                       s2_vld_q;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;
    logic [EXP_SIZE-1:0]        s2_exp_q;

    logic                       out_vld_q;
    fp16_t                      out_dat_q;
    fp16_t                      pack_d;

    assign adv           = !out_vld_q || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_vld_q;
    assign bus.out_data  = out_dat_q;

    // Products use the registered weights, so a write in the accept cycle lands one window later.
    always_comb begin
        for (int i = 0; i < N_TAPS; i++) begin
            prod_d[i] = PROD_W'(sm_to_signed(sm_elem_t'(bus.in_mant[i*ELEM_W +: ELEM_W])))
                      * PROD_W'(w_q[i]);
        end
    end

    always_comb begin
`ifdef BFP_CONV_MAC_BIAS_EN
        acc_d = ACC_W'(bias_q);
`else
        acc_d = '0;
`endif
        for (int i = 0; i < N_TAPS; i++) begin
            acc_d = acc_d + ACC_W'(prod_q[i]);
        end
    end

    bfp_fp_pack u_pack (
        .acc_i     (acc_q),
        .max_exp_i (s2_exp_q),
        .fp_o      (pack_d)
    );

    // Weight writes are independent of the pipeline and proceed during stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_TAPS; i++) w_q[i] <= '0;
`ifdef BFP_CONV_MAC_BIAS_EN
            bias_q <= '0;
`endif
        end else if (bus.w_load) begin
            if (bus.w_addr < 4'(N_TAPS)) begin
                w_q[bus.w_addr] <= bus.w_data;
            end
`ifdef BFP_CONV_MAC_BIAS_EN
            else if (bus.w_addr == 4'(N_TAPS)) begin
                bias_q <= BIAS_W'($signed(bus.w_data));
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_exp_q  <= '0;
            for (int i = 0; i < N_TAPS; i++) prod_q[i] <= '0;
            s2_vld_q  <= 1'b0;
            acc_q     <= '0;
            s2_exp_q  <= '0;
            out_vld_q <= 1'b0;
            out_dat_q <= FP16_ZERO;
        end else if (adv) begin
            s1_vld_q  <= bus.in_valid;
            prod_q    <= prod_d;
            s1_exp_q  <= bus.in_max_exp;
            s2_vld_q  <= s1_vld_q;
            acc_q     <= acc_d;
            s2_exp_q  <= s1_exp_q;
            out_vld_q <= s2_vld_q;
            out_dat_q <= s2_vld_q ? pack_d : FP16_ZERO;
        end
    end

endmodule

// File: tb/tb_bfp_conv_mac.sv
// Self-checking bench for bfp_conv_mac against an arithmetic reference model.
// Latency: expects results 3 cycles after acceptance when no stall intervenes.
// Backpressure: drives out_ready low in bursts and checks in_ready follows.
module tb_bfp_conv_mac;
    import bfp_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bfp_conv_mac_if bus();

    bfp_conv_mac dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    int wm [N_TAPS];
    int bias_m;
    int ws [N_TAPS];
    int cyc        = 0;
    int last_stall = -1;
    bit last_acc;
    bit last_fire;
    logic [15:0] exp_q [$];
    int          acc_cyc_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Value of the window in accumulator units: sum(M_i * w_i) + bias.
    function automatic longint window_acc();
        longint s = bias_m;
        for (int i = 0; i < N_TAPS; i++) s += longint'(ws[i]) * longint'(wm[i]);
        return s;
    endfunction

    function automatic logic [15:0] ref_fp(input longint acc, input int me);
        longint mag, frac;
        int     p, e;
        logic   s;
        if (acc == 0) return 16'h0000;
        s   = (acc < 0);
        mag = s ? -acc : acc;
        p = 0;
        while ((longint'(1) << (p + 1)) <= mag) p++;
        e = p + me - MANT_SIZE - WEIGHT_FRAC;
        if (e <= 0) return 16'h0000;
        if (e >= 31) return s ? 16'hFBFF : 16'h7BFF;
        frac = ((mag << MANT_SIZE) >> p) - (longint'(1) << MANT_SIZE);
        return {s, e[4:0], frac[9:0]};
    endfunction

    task automatic step(input bit iv, input int me, input bit wl, input int wa, input int wd,
                        input bit ordy, input bit r);
        logic [10:0] el;
        logic [7:0]  wd8;
        int          a, ac;
        logic [15:0] ex;
        @(negedge clk);
        rst = r;
        bus.in_valid = iv;
        for (int i = 0; i < N_TAPS; i++) begin
            a  = (ws[i] < 0) ? -ws[i] : ws[i];
            el = {(ws[i] < 0), a[9:0]};
            bus.in_mant[i*ELEM_W +: ELEM_W] = el;
        end
        bus.in_max_exp = me[4:0];
        bus.w_load     = wl;
        bus.w_addr     = wa[3:0];
        wd8            = wd[7:0];
        bus.w_data     = wd8;
        bus.out_ready  = ordy;
        #1;
        last_acc  = 1'b0;
        last_fire = 1'b0;
        if (r) begin
            foreach (wm[i]) wm[i] = 0;
            bias_m = 0;
            exp_q.delete();
            acc_cyc_q.delete();
        end else begin
            check("in_ready", {31'b0, bus.in_ready}, {31'b0, (!bus.out_valid || ordy)});
            if (bus.out_valid && !ordy) last_stall = cyc;
            if (bus.out_valid && ordy) begin
                last_fire = 1'b1;
                check("out_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    ex = exp_q.pop_front();
                    ac = acc_cyc_q.pop_front();
                    check("out_data", {16'b0, bus.out_data}, {16'b0, ex});
                    if (ac > last_stall) check("latency", cyc - ac, 3);
                end
            end
            if (iv && bus.in_ready) begin
                last_acc = 1'b1;
                exp_q.push_back(ref_fp(window_acc(), me));
                acc_cyc_q.push_back(cyc);
            end
            if (wl) begin
                if (wa < N_TAPS) wm[wa] = $signed(wd8);
`ifdef BFP_CONV_MAC_BIAS_EN
                if (wa == N_TAPS) bias_m = $signed(wd8);
`endif
            end
        end
        cyc++;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic load_w(input int a, input int d);
        step(0, 0, 1, a, d, 1, 0);
    endtask

    task automatic load_all(input int d);
        for (int i = 0; i < N_TAPS; i++) load_w(i, d);
    endtask

    task automatic set_ws(input int v);
        for (int i = 0; i < N_TAPS; i++) ws[i] = v;
    endtask

    task automatic drain();
        int budget = 0;
        while (exp_q.size() != 0 && budget < 40) begin
            idle();
            budget++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic rand_window(output int me);
        for (int i = 0; i < N_TAPS; i++) ws[i] = int'($urandom_range(0, 2046)) - 1023;
        me = int'($urandom_range(0, 31));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int me;
        int n_acc, n_out, stall_left, budget;
        bit iv, ordy, wl;

        bus.in_valid = 0; bus.in_mant = '0; bus.in_max_exp = '0;
        bus.w_load = 0; bus.w_addr = '0; bus.w_data = '0; bus.out_ready = 1;
        set_ws(0);
        rst = 1;
        step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 1);
        idle();
        check("rst_out_valid", {31'b0, bus.out_valid}, 0);
        check("rst_out_data", {16'b0, bus.out_data}, 0);
        check("rst_in_ready", {31'b0, bus.in_ready}, 1);

        // Weights are zero after reset.
        set_ws(1023);
        step(1, 20, 0, 0, 0, 1, 0);
        drain();

        // Unity kernel, all +512 at exponent 15.
        load_all(8'h40);
        set_ws(512);
        step(1, 15, 0, 0, 0, 1, 0);
        drain();

        // Alternating +/-1.0 kernel; second window cancels exactly.
        for (int i = 0; i < N_TAPS; i++) load_w(i, (i % 2 == 0) ? 8'h40 : 8'hC0);
        set_ws(100); ws[8] = -100;
        step(1, 10, 0, 0, 0, 1, 0);
        ws[8] = 0;
        step(1, 10, 0, 0, 0, 1, 0);
        drain();

        // Saturation, positive then negative, back to back.
        load_all(8'h7F);
        set_ws(1023);
        step(1, 30, 0, 0, 0, 1, 0);
        set_ws(-1023);
        step(1, 30, 0, 0, 0, 1, 0);
        drain();

        // Underflow and a short (left-aligned) magnitude.
        load_all(0);
        load_w(0, 8'h40);
        set_ws(0); ws[0] = 1;
        step(1, 1, 0, 0, 0, 1, 0);
        ws[0] = 5;
        step(1, 20, 0, 0, 0, 1, 0);
        ws[0] = -5;
        step(1, 20, 0, 0, 0, 1, 0);
        drain();

        // Weight written in the accept cycle applies to the following window.
        load_all(8'h40);
        set_ws(512);
        step(1, 15, 1, 4, 8'h80, 1, 0);
        check("race_acc0", {31'b0, last_acc}, 1);
        step(1, 15, 0, 0, 0, 1, 0);
        check("race_acc1", {31'b0, last_acc}, 1);
        drain();

        // Out-of-range addresses (9 is the bias slot when that build option is on).
        load_w(9, 8'h40);
        load_w(12, 8'h7F);
        load_w(15, 8'h01);
        set_ws(1);
        step(1, 25, 0, 0, 0, 1, 0);
        set_ws(0);
        step(1, 25, 0, 0, 0, 1, 0);
        step(1, 16, 0, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 1, 0);
        drain();

        // Backpressure: five windows, out_ready low for four cycles after the first result.
        for (int i = 0; i < N_TAPS; i++) load_w(i, int'($urandom_range(0, 255)));
        n_acc = 0; n_out = 0; stall_left = -1; budget = 0;
        rand_window(me);
        while ((n_acc < 5 || exp_q.size() != 0) && budget < 60) begin
            ordy = (stall_left <= 0);
            step(n_acc < 5, me, 0, 0, 0, ordy, 0);
            if (!ordy) check("bp_in_ready_low", {31'b0, bus.in_ready}, 0);
            if (last_acc) begin n_acc++; rand_window(me); end
            if (last_fire) begin
                n_out++;
                if (stall_left < 0) stall_left = 5;
            end
            if (stall_left > 0) stall_left--;
            budget++;
        end
        check("bp_accepted", n_acc, 5);
        check("bp_delivered", n_out, 5);

        // Random traffic with concurrent weight writes and random backpressure.
        rand_window(me);
        for (int k = 0; k < 400; k++) begin
            iv   = ($urandom_range(0, 99) < 70);
            ordy = ($urandom_range(0, 99) < 75);
            wl   = ($urandom_range(0, 99) < 15);
            step(iv, me, wl, int'($urandom_range(0, 15)), int'($urandom_range(0, 255)), ordy, 0);
            if (last_acc) rand_window(me);
        end
        drain();

        // Reset with windows in flight drops them and clears the weights.
        load_all(8'h40);
        set_ws(300);
        step(1, 20, 0, 0, 0, 1, 0);
        step(1, 20, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 1);
        idle();
        check("rst_mid_valid", {31'b0, bus.out_valid}, 0);
        idle(); idle(); idle();
        check("rst_mid_quiet", {31'b0, bus.out_valid}, 0);
        set_ws(1023);
        step(1, 20, 0, 0, 0, 1, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
